subbytes_engine: RTL
====================

// Module: subbytes_engine
// PURPOSE
//  Forward AES-128 SubBytes unit for the encryption datapath; the encrypt-side counterpart of the inverse S-box.
//  Accepts one 128-bit state, substitutes every byte through the forward S-box and presents the result.
//  Processes BPC bytes per cycle, trading S-box area against latency.
//  Uses a valid/ready handshake on input and output, and sits between AddRoundKey and ShiftRows in the round loop.
// PARAMETERS
//  BPC  4  bytes substituted per cycle; legal 1,2,4,8,16; any other value is an elaboration error
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge
//  rst_n      in   1    reset, synchronous, active-low
//  in_valid   in   1    state_in is valid
//  in_ready   out  1    engine accepts state_in this cycle
//  state_in   in   128  input state; byte i = state_in[127-8i -: 8] (byte 0 at the MSB, FIPS-197 column-major order)
//  out_valid  out  1    state_out is valid
//  out_ready  in   1    downstream accepts state_out
//  state_out  out  128  substituted state, same byte order as state_in
//  busy       out  1    high while in BUSY
// BEHAVIOUR
//  - NCYC = 16/BPC. The FSM has three states: IDLE, BUSY and DONE.
//  - Reset (rst_n=0 at a clk edge):
//    - FSM goes to IDLE; step counter, work register and state_out are cleared to 0; out_valid=0.
//    - in_ready is forced to 0 while rst_n=0.
//    - Reset mid-operation discards the current state without emitting it.
//  - in_ready = rst_n & (IDLE | (DONE & out_ready)). This is combinational on out_ready, which allows back-to-back operation.
//  - Accept happens when in_valid & in_ready:
//    - state_in is loaded into the work register; cnt=0; FSM goes to BUSY.
//    - A new accept in DONE has priority over returning to IDLE, so DONE goes straight to BUSY.
//  - In BUSY, each cycle:
//    - Bytes cnt*BPC .. cnt*BPC+BPC-1 of the work register are replaced by sbox(byte).
//    - cnt increments. When cnt==NCYC-1 the FSM goes to DONE and cnt wraps to 0.
//  - In DONE:
//    - out_valid=1; state_out = the work register, held stable until out_ready.
//    - out_ready=1 with no new accept: out_valid drops next cycle and the FSM goes to IDLE.
//  - Latency: accept at edge T gives out_valid=1 from edge T+NCYC (BPC=4: 4 cycles; BPC=16: 1 cycle).
//  - Throughput: one state per NCYC+1 cycles with back-to-back accept in DONE.
//  - in_valid is ignored in BUSY. state_in may change freely after the accept.
//  - out_ready is ignored unless the FSM is in DONE.
//  - cnt width is clog2(NCYC), minimum 1 bit. For BPC=16, BUSY lasts exactly one cycle.
//  - No arithmetic beyond the counter. The S-box is a pure lookup: 8-bit in, 8-bit out.
// STRUCTURE
//  - aes_pkg holds: AES_STATE_W=128, AES_NBYTES=16, the FSM state enum (IDLE/BUSY/DONE), and a byte-select helper function for byte i.
//  - Sub-module sbox_fwd is a combinational 256-entry forward S-box, in[7:0] -> out[7:0].
//    - BPC instances are generated, each fed from the byte mux selected by cnt.
//  - The top level contains only the FSM, the counter, the work register and the write-back mux.
// TESTING
//  1. Single-byte LUT check, BPC=16:
//     - bytes 00,01,53,ff -> 63,7c,ed,16.
//     - Sweep all 256 byte values; round-trip each through the inverse S-box -> identity.
//  2. FIPS-197 App.B round-1 vector, BPC=4:
//     - in 193de3bea0f4e22b9ac68d2ae9f84808 -> out d42711aee0bf98f1b8b45de51e415230.
//     - out_valid asserts exactly 4 cycles after the accept.
//  3. Backpressure:
//     - Hold out_ready=0 for 10 cycles in DONE -> state_out stable, out_valid=1, in_ready=0.
//     - Then pulse out_ready -> out_valid drops next cycle.
//  4. Back-to-back:
//     - in_valid held high with two states and out_ready=1 -> second accept in the same cycle as the first output.
//     - Both results correct; in_ready=0 throughout BUSY.
//  5. Reset mid-BUSY:
//     - Drop rst_n at cnt=2 -> next edge IDLE, out_valid=0, state_out=0, no spurious output.
//     - The next transaction is correct.
//  6. Parameter sweep:
//     - Repeat test 2 for BPC=1,2,8,16 -> same output; latency 16, 8, 2, 1 cycles respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and byte helpers for the SubBytes engine.
// Byte 0 of a state sits in the most significant byte (FIPS-197 column-major order).
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } engine_state_t;

    typedef logic [AES_NBYTES-1:0][7:0] state_bytes_t;

    function automatic logic [7:0] byte_sel(input logic [AES_STATE_W-1:0] st, input logic [3:0] idx);
        state_bytes_t b;
        b = st;
        return b[4'd15 - idx];
    endfunction

endpackage

// File: rtl/sbox_fwd.sv
// Combinational forward AES S-box: one byte in, its substitution out.
module sbox_fwd (
    input  logic [7:0] data,
    output logic [7:0] result
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign result = SBOX[data];

endmodule

// File: rtl/subbytes_engine.sv
// Forward AES SubBytes engine: substitutes BPC bytes of the held state per cycle
// between a valid/ready input and a valid/ready output.
module subbytes_engine
    import aes_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    localparam int NCYC  = AES_NBYTES / BPC;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bpc_check
        $error("subbytes_engine: BPC must be 1, 2, 4, 8 or 16");
    end

    engine_state_t          state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [AES_STATE_W-1:0] work, work_sub;
    logic [7:0]             sub_in  [BPC];
    logic [7:0]             sub_out [BPC];
    logic                   accept;

    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign state_out = work;

    always_comb begin
        for (int j = 0; j < BPC; j++) begin
            sub_in[j] = byte_sel(work, 4'(int'(cnt) * BPC + j));
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_sbox
        sbox_fwd u_sbox (
            .data   (sub_in[g]),
            .result (sub_out[g])
        );
    end

    // Write the substituted slice back over the same byte positions of the work register.
    always_comb begin
        state_bytes_t wb;
        wb = work;
        for (int j = 0; j < BPC; j++) begin
            wb[4'd15 - 4'(int'(cnt) * BPC + j)] = sub_out[j];
        end
        work_sub = wb;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                // A fresh accept wins over draining to IDLE so back-to-back states lose no cycle.
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work <= '0;
        end else if (accept) begin
            work <= state_in;
        end else if (state == BUSY) begin
            work <= work_sub;
        end
    end

endmodule
